// File: rtl/gvp_pack_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gvp_pack_pkg
//  Description : Shared constants and types for the GVP store packer.
//                Record tag types, record lengths (with and without the
//                optional timestamp word), record-type and serializer-state
//                enums, and the snapshot record carried between stages.
//  Revision    : 1.0  initial release
// ============================================================================
package gvp_pack_pkg;

  // Tag type byte, bits [31:24] of the first word of every record
  localparam logic [7:0] c_TAG_HDR  = 8'hA1;
  localparam logic [7:0] c_TAG_DATA = 8'hD1;
  localparam logic [7:0] c_TAG_END  = 8'hEF;

  // Record lengths in 32-bit words
  localparam logic [3:0] c_LEN_HDR     = 4'd6;
  localparam logic [3:0] c_LEN_DATA    = 4'd5;
  localparam logic [3:0] c_LEN_END     = 4'd1;
  localparam logic [3:0] c_LEN_HDR_TS  = 4'd7;
  localparam logic [3:0] c_LEN_DATA_TS = 4'd6;
  localparam logic [3:0] c_LEN_END_TS  = 4'd2;

  typedef enum logic [1:0] {
    REC_NONE = 2'd0,
    REC_DATA = 2'd1,
    REC_HDR  = 2'd2,
    REC_END  = 2'd3
  } rec_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ser_state_e;

  // Snapshot of the vector state taken on a qualifying tick
  typedef struct packed {
    rec_type_e   typ;
    logic [7:0]  seq;
    logic [15:0] sect;
    logic [31:0] opt;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] u;
  } snap_t;

  function automatic logic [3:0] rec_len(input rec_type_e t, input logic ts_en);
    logic [3:0] len;
    case (t)
      REC_HDR:  len = ts_en ? c_LEN_HDR_TS  : c_LEN_HDR;
      REC_DATA: len = ts_en ? c_LEN_DATA_TS : c_LEN_DATA;
      default:  len = ts_en ? c_LEN_END_TS  : c_LEN_END;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] rec_tag(input rec_type_e t);
    logic [7:0] tag;
    case (t)
      REC_HDR:  tag = c_TAG_HDR;
      REC_DATA: tag = c_TAG_DATA;
      default:  tag = c_TAG_END;
    endcase
    return tag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gvp_pack_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gvp_pack_fifo
//  Description : Synchronous first-word-fall-through FIFO, 2**DEPTH_N2 deep.
//                The head entry is visible on rd_data_o whenever valid_o is
//                high; rd_data_o reads zero when empty. Full is true full
//                capacity. flush_i empties the FIFO synchronously.
//  Ports       : clk_i, rst_ni (async, active low), flush_i,
//                wr_en_i/wr_data_i (push), rd_en_i (pop when valid),
//                rd_data_o, valid_o, full_o, level_o (occupancy in entries)
//  Revision    : 1.0  initial release
// ============================================================================
module gvp_pack_fifo #(
  parameter int DEPTH_N2 = 9,
  parameter int WIDTH    = 33
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               rd_en_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               valid_o,
  output logic               full_o,
  output logic [DEPTH_N2:0]  level_o
);

  localparam int                  c_DEPTH      = 2**DEPTH_N2;
  localparam logic [DEPTH_N2:0]   c_LEVEL_FULL = (DEPTH_N2+1)'(c_DEPTH);
  localparam logic [DEPTH_N2:0]   c_LEVEL_ONE  = (DEPTH_N2+1)'(1);
  localparam logic [DEPTH_N2-1:0] c_PTR_ONE    = DEPTH_N2'(1);

  logic [WIDTH-1:0]    mem_q [c_DEPTH];
  logic [DEPTH_N2-1:0] wr_ptr_q;
  logic [DEPTH_N2-1:0] rd_ptr_q;
  logic [DEPTH_N2:0]   level_q;
  logic                w_push;
  logic                w_pop;

  assign full_o    = (level_q == c_LEVEL_FULL);
  assign valid_o   = (level_q != '0);
  assign level_o   = level_q;
  assign w_push    = wr_en_i & ~full_o;
  assign w_pop     = rd_en_i & valid_o;
  // Gate the head word so the stream reads zero when nothing is valid
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + c_LEVEL_ONE;
        2'b01:   level_q <= level_q - c_LEVEL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gvp_store_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gvp_store_packer
//  Description : Samples the GVP store_data trigger on qualifying ticks
//                (gvp_tick & enable), snapshots the vector state into a
//                one-deep pending slot, serializes it into tagged 32-bit
//                records (header / data / end) and streams them out of a
//                FWFT FIFO over AXI-Stream. Overflow of the pending slot
//                drops the record and counts it in a saturating counter.
//  Config      : GVP_PACK_TIMESTAMP_EN - when defined, a free-running a_clk
//                cycle counter is latched per tick and inserted as word 1
//                of every record.
//  Ports       : a_clk, a_resetn (async, active low); GVP inputs gvp_tick,
//                store_data, gvp_finished, x, y, z, u, options, section;
//                control enable, flush; AXI-Stream master m_axis_*;
//                status fifo_level, drop_count, overrun, busy.
//  Revision    : 1.0  initial release
// ============================================================================
module gvp_store_packer #(
  parameter int FIFO_DEPTH_N2 = 9,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                     a_clk,
  input  logic                     a_resetn,
  input  logic                     gvp_tick,
  input  logic [1:0]               store_data,
  input  logic                     gvp_finished,
  input  logic [31:0]              x,
  input  logic [31:0]              y,
  input  logic [31:0]              z,
  input  logic [31:0]              u,
  input  logic [31:0]              options,
  input  logic [31:0]              section,
  input  logic                     enable,
  input  logic                     flush,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [FIFO_DEPTH_N2:0]   fifo_level,
  output logic [DROP_CNT_W-1:0]    drop_count,
  output logic                     overrun,
  output logic                     busy
);

  import gvp_pack_pkg::*;

`ifdef GVP_PACK_TIMESTAMP_EN
  localparam logic c_TS_EN = 1'b1;
`else
  localparam logic c_TS_EN = 1'b0;
`endif
  localparam logic [DROP_CNT_W-1:0] c_DROP_ONE = DROP_CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] c_DROP_MAX = '1;

  // --------------------------------------------------------------------------
  // Record selection and pending snapshot slot
  // --------------------------------------------------------------------------
  rec_type_e             w_sel;
  logic                  w_qual;
  logic                  w_accept;
  logic                  w_drop;
  snap_t                 w_snap;
  snap_t                 pend_q;
  logic                  pend_vld_q;
  logic [7:0]            seq_q;
  logic                  end_sent_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  overrun_q;
  logic                  w_unused_sect;

  assign w_qual        = gvp_tick & enable;
  assign w_unused_sect = ^section[31:16];

  always_comb begin
    w_sel = REC_NONE;
    if (w_qual) begin
      case (store_data)
        2'd1: w_sel = REC_DATA;
        2'd2: begin
          if (!gvp_finished)    w_sel = REC_HDR;
          else if (!end_sent_q) w_sel = REC_END;
        end
        default: w_sel = REC_NONE;
      endcase
    end
  end

  // The slot counts as full for the whole cycle it is being unloaded, so a
  // record is accepted only into a slot that was already empty.
  assign w_accept = (w_sel != REC_NONE) & ~pend_vld_q;
  assign w_drop   = (w_sel != REC_NONE) &  pend_vld_q;

  assign w_snap = '{typ:  w_sel,
                    seq:  seq_q,
                    sect: section[15:0],
                    opt:  options,
                    x:    x,
                    y:    y,
                    z:    z,
                    u:    u};

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  ser_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  snap_t       act_q;
  logic        w_load;
  logic        w_wr;
  logic        w_last;
  logic        w_fifo_full;
  logic [3:0]  w_len;
  logic [3:0]  w_body;
  logic [31:0] w_word;

  assign w_len  = rec_len(act_q.typ, c_TS_EN);
  assign w_last = (idx_q == (w_len - 4'd1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_load  = 1'b0;
    w_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          w_load  = 1'b1;
          idx_d   = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!w_fifo_full) begin
          w_wr = 1'b1;
          if (w_last) begin
            // Chain straight into the next record when one is waiting
            if (pend_vld_q) begin
              w_load = 1'b1;
              idx_d  = 4'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef GVP_PACK_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] pend_ts_q;
  logic [31:0] act_ts_q;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      ts_cnt_q  <= '0;
      pend_ts_q <= '0;
      act_ts_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (flush) begin
        pend_ts_q <= '0;
        act_ts_q  <= '0;
      end else begin
        if (w_accept) pend_ts_q <= ts_cnt_q;
        if (w_load)   act_ts_q  <= pend_ts_q;
      end
    end
  end
`endif

  // Word selection: w_body indexes the header layout
  // (0 tag, 1 options, 2 x, 3 y, 4 z, 5 u); data records skip the options
  // slot and the optional timestamp shifts everything after the tag by one.
  always_comb begin
    w_body = idx_q;
`ifdef GVP_PACK_TIMESTAMP_EN
    if (idx_q != 4'd0) w_body = idx_q - 4'd1;
`endif
    if ((act_q.typ != REC_HDR) && (w_body != 4'd0)) w_body = w_body + 4'd1;
    case (w_body)
      4'd0:    w_word = {rec_tag(act_q.typ), act_q.seq, act_q.sect};
      4'd1:    w_word = act_q.opt;
      4'd2:    w_word = act_q.x;
      4'd3:    w_word = act_q.y;
      4'd4:    w_word = act_q.z;
      4'd5:    w_word = act_q.u;
      default: w_word = '0;
    endcase
`ifdef GVP_PACK_TIMESTAMP_EN
    if (idx_q == 4'd1) w_word = act_ts_q;
`endif
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seq_q      <= '0;
      end_sent_q <= 1'b0;
      drop_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else if (flush) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seq_q      <= '0;
      end_sent_q <= 1'b0;
      drop_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (w_load) act_q <= pend_q;

      // accept and load are mutually exclusive: they need opposite slot states
      if (w_accept) begin
        pend_q     <= w_snap;
        pend_vld_q <= 1'b1;
        seq_q      <= seq_q + 8'd1;
      end else if (w_load) begin
        pend_vld_q <= 1'b0;
      end

      if (w_qual && !gvp_finished) begin
        end_sent_q <= 1'b0;
      end else if (w_accept && (w_sel == REC_END)) begin
        end_sent_q <= 1'b1;
      end

      if (w_drop) begin
        overrun_q <= 1'b1;
        if (drop_cnt_q != c_DROP_MAX) drop_cnt_q <= drop_cnt_q + c_DROP_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (data + tlast)
  // --------------------------------------------------------------------------
  logic [32:0] w_fifo_rd;

  gvp_pack_fifo #(
    .DEPTH_N2 (FIFO_DEPTH_N2),
    .WIDTH    (33)
  ) u_fifo (
    .clk_i     (a_clk),
    .rst_ni    (a_resetn),
    .flush_i   (flush),
    .wr_en_i   (w_wr),
    .wr_data_i ({w_last, w_word}),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (w_fifo_rd),
    .valid_o   (m_axis_tvalid),
    .full_o    (w_fifo_full),
    .level_o   (fifo_level)
  );

  assign m_axis_tdata = w_fifo_rd[31:0];
  assign m_axis_tlast = w_fifo_rd[32];
  assign drop_count   = drop_cnt_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == ST_EMIT) | pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_gvp_store_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gvp_store_packer
//  Description : Self-checking bench for gvp_store_packer (default build).
//                Directed steps plus a randomized phase checked against a
//                record-level reference model of the output stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gvp_store_packer;

  localparam int N2 = 9;
  localparam int DW = 16;

  logic          a_clk = 1'b0;
  logic          a_resetn = 1'b0;
  logic          gvp_tick = 1'b0;
  logic [1:0]    store_data = 2'd0;
  logic          gvp_finished = 1'b0;
  logic [31:0]   x = '0, y = '0, z = '0, u = '0, options = '0, section = '0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [N2:0]   fifo_level;
  logic [DW-1:0] drop_count;
  logic          overrun;
  logic          busy;

  gvp_store_packer #(.FIFO_DEPTH_N2(N2), .DROP_CNT_W(DW)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .gvp_tick(gvp_tick),
    .store_data(store_data), .gvp_finished(gvp_finished),
    .x(x), .y(y), .z(z), .u(u), .options(options), .section(section),
    .enable(enable), .flush(flush),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .fifo_level(fifo_level), .drop_count(drop_count),
    .overrun(overrun), .busy(busy)
  );

  always #5 a_clk = ~a_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // ---------------- stream monitor ----------------
  int          cyc = 0;
  logic [32:0] got_q[$];
  int          got_t[$];
  logic        hold_pend = 1'b0;
  logic [32:0] hold_word = '0;

  always @(posedge a_clk) cyc <= cyc + 1;

  always @(negedge a_clk) begin
    if (hold_pend && m_axis_tvalid)
      chk("stable_under_stall", {m_axis_tlast, m_axis_tdata}, hold_word);
    hold_pend = m_axis_tvalid && !m_axis_tready && a_resetn && !flush;
    hold_word = {m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tlast, m_axis_tdata});
      got_t.push_back(cyc);
    end
  end

  function automatic logic [32:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // ---------------- reference model ----------------
  logic [32:0] exp_q[$];
  logic [7:0]  m_seq = 8'd0;
  bit          m_end_sent = 1'b0;
  bit          model_on = 1'b1;

  task automatic model_tick(input logic [1:0] sd, input logic fin);
    logic [31:0] w[$];
    logic [7:0]  t;
    t = 8'h00;
    if (!fin) m_end_sent = 1'b0;
    if (sd == 2'd1) t = 8'hD1;
    else if (sd == 2'd2 && !fin) t = 8'hA1;
    else if (sd == 2'd2 && !m_end_sent) begin
      t = 8'hEF;
      m_end_sent = 1'b1;
    end
    if (t == 8'h00) return;
    w.push_back({t, m_seq, section[15:0]});
    if (t == 8'hA1) w.push_back(options);
    if (t != 8'hEF) begin
      w.push_back(x); w.push_back(y); w.push_back(z); w.push_back(u);
    end
    foreach (w[i]) exp_q.push_back({(i == w.size() - 1), w[i]});
    m_seq = m_seq + 8'd1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge a_clk);
    #1;
  endtask

  task automatic tick(input logic [1:0] sd, input logic fin, input logic en);
    store_data   = sd;
    gvp_finished = fin;
    enable       = en;
    gvp_tick     = 1'b1;
    if (en && model_on) model_tick(sd, fin);
    step();
    gvp_tick = 1'b0;
  endtask

  task automatic clear_model();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    m_seq      = 8'd0;
    m_end_sent = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_model();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < budget) begin
      step();
      n++;
    end
    step();
    chk({tag, "_drain_timeout"}, (n < budget), 1'b1);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) chk({tag, "_word"}, got_at(i), exp_q[i]);
  endtask

  task automatic set_vec(input logic [31:0] sx, input logic [31:0] sy,
                         input logic [31:0] sz, input logic [31:0] su,
                         input logic [31:0] so, input logic [31:0] ss);
    x = sx; y = sy; z = sz; u = su; options = so; section = ss;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int nrec;
    int pos;
    int len;
    logic [7:0]  es;
    logic [31:0] tagw;

    // Reset state
    step(); step();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata",  m_axis_tdata, 32'h0);
    chk("rst_tlast",  m_axis_tlast, 1'b0);
    chk("rst_level",  fifo_level, 0);
    chk("rst_drop",   drop_count, 0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy",   busy, 1'b0);
    a_resetn = 1'b1;
    step();
    chk("post_rst_tvalid", m_axis_tvalid, 1'b0);
    m_axis_tready = 1'b1;
    enable = 1'b1;

    // Data record and its latency
    set_vec(32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd5);
    tick(2'd1, 1'b0, 1'b1);
    chk("data_busy", busy, 1'b1);
    @(negedge a_clk); chk("lat_c1_tvalid", m_axis_tvalid, 1'b0);
    @(negedge a_clk); chk("lat_c2_tvalid", m_axis_tvalid, 1'b0);
    @(negedge a_clk); chk("lat_c3_tvalid", m_axis_tvalid, 1'b1);
    drain(100, "data");
    compare_stream("data");
    chk("data_tag",  got_at(0), {1'b0, 32'hD1000005});
    chk("data_last", got_at(4), {1'b1, 32'h4});
    chk("data_idle", busy, 1'b0);

    // Header then data
    do_flush();
    set_vec(32'd1, 32'd2, 32'd3, 32'd4, 32'h10, 32'd5);
    tick(2'd2, 1'b0, 1'b1);
    repeat (8) step();
    tick(2'd1, 1'b0, 1'b1);
    drain(100, "hdr");
    compare_stream("hdr");
    chk("hdr_tag",   got_at(0), {1'b0, 32'hA1000005});
    chk("hdr_opt",   got_at(1), {1'b0, 32'h10});
    chk("hdr_last",  got_at(5), {1'b1, 32'h4});
    chk("hdr_next",  got_at(6), {1'b0, 32'hD1010005});

    // Finished held for 10 ticks: exactly one end record
    do_flush();
    for (int i = 0; i < 10; i++) begin
      tick(2'd2, 1'b1, 1'b1);
      step(); step();
    end
    drain(100, "end");
    chk("end_count", got_q.size(), 1);
    chk("end_word",  got_at(0), {1'b1, 32'hEF000005});
    // finished sampled low re-arms the end record
    tick(2'd0, 1'b0, 1'b1);
    step(); step();
    tick(2'd2, 1'b1, 1'b1);
    drain(100, "end2");
    compare_stream("end2");
    chk("end2_word", got_at(1), {1'b1, 32'hEF010005});

    // Burst: two ticks two cycles apart, back-to-back output
    do_flush();
    set_vec(32'h11, 32'h12, 32'h13, 32'h14, 32'h0, 32'h7);
    tick(2'd1, 1'b0, 1'b1);
    step();
    set_vec(32'h21, 32'h22, 32'h23, 32'h24, 32'h0, 32'h7);
    tick(2'd1, 1'b0, 1'b1);
    drain(100, "burst");
    compare_stream("burst");
    chk("burst_gap", (got_t.size() == 10) ? (got_t[9] - got_t[0]) : -1, 9);
    chk("burst_drop", drop_count, 0);

    // Backpressure: FIFO fills, records drop, stream stays whole
    do_flush();
    model_on = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_vec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick(2'($urandom_range(1, 2)), 1'b0, 1'b1);
      step();
    end
    chk("bp_level",   fifo_level, 512);
    chk("bp_overrun", overrun, 1'b1);
    chk("bp_dropped", (drop_count != 0), 1'b1);
    m_axis_tready = 1'b1;
    drain(2000, "bp");
    pos  = 0;
    nrec = 0;
    es   = 8'd0;
    while (pos < got_q.size()) begin
      tagw = got_q[pos][31:0];
      len  = (tagw[31:24] == 8'hA1) ? 6 : (tagw[31:24] == 8'hD1) ? 5 : 0;
      chk("bp_type_ok", (len != 0), 1'b1);
      if (len == 0) break;
      chk("bp_seq", tagw[23:16], es);
      for (int k = 0; k < len; k++) chk("bp_tlast", got_at(pos + k) >> 32, (k == len - 1));
      pos  = pos + len;
      es   = es + 8'd1;
      nrec = nrec + 1;
    end
    chk("bp_whole",   pos, got_q.size());
    chk("bp_account", nrec + int'(drop_count), 300);
    model_on = 1'b1;

    // Flush mid-record (second record, word 2) after a drop
    do_flush();
    m_axis_tready = 1'b0;
    set_vec(32'd1, 32'd2, 32'd3, 32'd4, 32'd9, 32'd5);
    tick(2'd2, 1'b0, 1'b1);
    step();
    tick(2'd1, 1'b0, 1'b1);
    step();
    tick(2'd1, 1'b0, 1'b1);
    chk("mid_drop", drop_count, 1);
    chk("mid_overrun", overrun, 1'b1);
    repeat (5) step();
    chk("mid_level", fifo_level, 8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_model();
    chk("flush_level",   fifo_level, 0);
    chk("flush_tvalid",  m_axis_tvalid, 1'b0);
    chk("flush_drop",    drop_count, 0);
    chk("flush_overrun", overrun, 1'b0);
    chk("flush_busy",    busy, 1'b0);
    m_axis_tready = 1'b1;
    tick(2'd1, 1'b0, 1'b1);
    drain(100, "flush_after");
    compare_stream("flush_after");
    chk("flush_seq0", got_at(0), {1'b0, 32'hD1000005});

    // Reset mid-record (word 2)
    m_axis_tready = 1'b0;
    tick(2'd2, 1'b0, 1'b1);
    repeat (3) step();
    chk("prerst_level", fifo_level, 2);
    a_resetn = 1'b0;
    #1;
    chk("arst_level",  fifo_level, 0);
    chk("arst_tvalid", m_axis_tvalid, 1'b0);
    chk("arst_busy",   busy, 1'b0);
    step();
    a_resetn = 1'b1;
    clear_model();
    m_axis_tready = 1'b1;
    step();
    tick(2'd1, 1'b0, 1'b1);
    drain(100, "rst_after");
    compare_stream("rst_after");
    chk("rst_seq0", got_at(0), {1'b0, 32'hD1000005});

    // Randomized phase against the reference model
    do_flush();
    for (int i = 0; i < 80; i++) begin
      set_vec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) != 0));
      enable = 1'b1;
      for (int g = 0; g < int'($urandom_range(7, 10)); g++) begin
        store_data    = 2'($urandom_range(0, 3));
        m_axis_tready = 1'($urandom_range(0, 1));
        step();
      end
    end
    m_axis_tready = 1'b1;
    drain(2000, "rand");
    compare_stream("rand");
    chk("rand_drop", drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
